stream_fanout: RTL and testbench

One-entry registered broadcast stage feeding one upstream AXI4-Stream word to NTAPS downstream consumers, each with its own valid/ready pair. It sits downstream of the stream delay lines, at the point where a buffered stream feeds several kernel inputs. Each word is held until every tap has accepted it. Taps that accept early are masked off, so no tap ever sees a word twice.

---
 rtl/stream_fanout.sv | 68 ++++++
 tb/tb_stream_fanout.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_fanout.sv
// One-entry registered broadcast stage: holds one upstream word until every tap has taken it.
// Optional transfer counter is built when STREAM_FANOUT_CNT_EN is defined; otherwise xfer_count is 0.
module stream_fanout #(
  parameter int STREAMW = 32,
  parameter int NTAPS   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STREAMW-1:0] in1_s0,
  input  logic               ivalid_in1_s0,
  output logic               iready,
  input  logic [NTAPS-1:0]   oready,
  output logic [NTAPS-1:0]   ovalid,
  output logic [STREAMW-1:0] out1_s0,
  output logic [31:0]        xfer_count
);

  logic               full;
  logic [STREAMW-1:0] data_q;
  logic [NTAPS-1:0]   pending;
  logic [NTAPS-1:0]   take;
  logic               last;
  logic               accept;

  assign ovalid  = {NTAPS{full}} & pending;
  assign out1_s0 = data_q;
  assign take    = ovalid & oready;

  // last: every tap still owed the word takes it this cycle, so the slot frees up now
  assign last    = full & ((pending & ~take) == '0);
  assign iready  = ~rst & (~full | last);
  assign accept  = ivalid_in1_s0 & iready;

  // NOTE: state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 1'b0;
      pending <= '0;
      data_q  <= '0;
    end else if (accept) begin
      full    <= 1'b1;
      pending <= '1;
      data_q  <= in1_s0;
    end else if (last) begin
      full    <= 1'b0;
      pending <= '0;
    end else if (full) begin
      pending <= pending & ~take;
    end
  end

`ifdef STREAM_FANOUT_CNT_EN
  logic [31:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (last) begin
      cnt <= cnt + 32'd1;
    end
  end

  assign xfer_count = cnt;
`else
  assign xfer_count = 32'd0;
`endif

endmodule

// File: tb/tb_stream_fanout.sv
// Directed self-checking bench for stream_fanout (NTAPS=2, STREAMW=32).
// Expected xfer_count follows STREAM_FANOUT_CNT_EN: delivered-word count when defined, else 0.
module tb_stream_fanout;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in1_s0;
  logic        ivalid_in1_s0;
  logic        iready;
  logic [1:0]  oready;
  logic [1:0]  ovalid;
  logic [31:0] out1_s0;
  logic [31:0] xfer_count;

  int total = 0;
  int bad   = 0;

  stream_fanout #(.STREAMW(32), .NTAPS(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .in1_s0        (in1_s0),
    .ivalid_in1_s0 (ivalid_in1_s0),
    .iready        (iready),
    .oready        (oready),
    .ovalid        (ovalid),
    .out1_s0       (out1_s0),
    .xfer_count    (xfer_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Expected counter value given the number of words fully delivered.
  function automatic logic [31:0] cnt_exp(input logic [31:0] n);
`ifdef STREAM_FANOUT_CNT_EN
    return n;
`else
    return 32'd0 & n;
`endif
  endfunction

  // Advance one clock edge and land 1 time unit after it, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] r);
    ivalid_in1_s0 = v;
    in1_s0        = d;
    oready        = r;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 2'b00);
    #2;
    check("rst_ovalid", 32'(ovalid), 32'h0);
    check("rst_out", out1_s0, 32'h0);
    check("rst_iready", 32'(iready), 32'h0);
    check("rst_count", xfer_count, 32'h0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("release_iready", 32'(iready), 32'h1);

    // Streaming, all taps ready: one word per cycle
    drive(1'b1, 32'h11, 2'b11);
    step();
    check("s1_ovalid", 32'(ovalid), 32'h3);
    check("s1_out", out1_s0, 32'h11);
    drive(1'b1, 32'h22, 2'b11);
    check("s1_iready", 32'(iready), 32'h1);
    step();
    check("s2_ovalid", 32'(ovalid), 32'h3);
    check("s2_out", out1_s0, 32'h22);
    drive(1'b1, 32'h33, 2'b11);
    check("s2_iready", 32'(iready), 32'h1);
    step();
    check("s3_ovalid", 32'(ovalid), 32'h3);
    check("s3_out", out1_s0, 32'h33);
    drive(1'b0, 32'h0, 2'b11);
    step();
    check("s_drain_ovalid", 32'(ovalid), 32'h0);
    check("s_count", xfer_count, cnt_exp(3));

    // Taps take at different times
    drive(1'b1, 32'hA5, 2'b01);
    step();
    drive(1'b0, 32'h0, 2'b01);
    check("a_c1_ovalid", 32'(ovalid), 32'h3);
    check("a_c1_iready", 32'(iready), 32'h0);
    check("a_c1_out", out1_s0, 32'hA5);
    step();
    check("a_c2_ovalid", 32'(ovalid), 32'h2);
    check("a_c2_iready", 32'(iready), 32'h0);
    check("a_c2_out", out1_s0, 32'hA5);
    step();
    check("a_c3_ovalid", 32'(ovalid), 32'h2);
    check("a_c3_iready", 32'(iready), 32'h0);
    check("a_c3_out", out1_s0, 32'hA5);
    // Cycle 4: tap1 takes while 0x5A arrives in the same cycle
    drive(1'b1, 32'h5A, 2'b10);
    check("a_c4_ovalid", 32'(ovalid), 32'h2);
    check("a_c4_iready", 32'(iready), 32'h1);
    check("a_c4_out", out1_s0, 32'hA5);
    step();
    check("b2b_ovalid", 32'(ovalid), 32'h3);
    check("b2b_out", out1_s0, 32'h5A);
    check("b2b_count", xfer_count, cnt_exp(4));
    drive(1'b0, 32'h0, 2'b11);
    step();
    check("b2b_drain_ovalid", 32'(ovalid), 32'h0);
    check("b2b_drain_count", xfer_count, cnt_exp(5));

    // Full stall: second word must wait
    drive(1'b1, 32'h77, 2'b00);
    step();
    drive(1'b1, 32'h88, 2'b00);
    for (int i = 0; i < 10; i++) begin
      check("stall_ovalid", 32'(ovalid), 32'h3);
      check("stall_out", out1_s0, 32'h77);
      check("stall_iready", 32'(iready), 32'h0);
      step();
    end
    drive(1'b1, 32'h88, 2'b11);
    check("unstall_iready", 32'(iready), 32'h1);
    check("unstall_out", out1_s0, 32'h77);
    step();
    check("next_out", out1_s0, 32'h88);
    check("next_ovalid", 32'(ovalid), 32'h3);
    drive(1'b0, 32'h0, 2'b11);
    step();
    check("stall_count", xfer_count, cnt_exp(7));

    // Reset while tap1 still pending
    drive(1'b1, 32'hC3, 2'b01);
    step();
    drive(1'b0, 32'h0, 2'b01);
    step();
    check("mid_ovalid", 32'(ovalid), 32'h2);
    rst = 1'b1;
    #1;
    check("mid_rst_ovalid", 32'(ovalid), 32'h0);
    check("mid_rst_out", out1_s0, 32'h0);
    check("mid_rst_iready", 32'(iready), 32'h0);
    check("mid_rst_count", xfer_count, 32'h0);
    step();
    rst = 1'b0;
    drive(1'b0, 32'h0, 2'b11);
    check("post_rst_iready", 32'(iready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_ovalid", 32'(ovalid), 32'h0);
      check("post_rst_out", out1_s0, 32'h0);
    end

`ifdef STREAM_FANOUT_CNT_EN
    // Counter wrap
    force dut.cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cnt;
    check("preload_count", xfer_count, 32'hFFFF_FFFF);
    drive(1'b1, 32'hE1, 2'b11);
    step();
    drive(1'b0, 32'h0, 2'b11);
    step();
    check("wrap_count", xfer_count, 32'h0);
`else
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'hF0 + 32'(i), 2'b11);
      step();
      check("five_out", out1_s0, 32'hF0 + 32'(i));
    end
    drive(1'b0, 32'h0, 2'b11);
    step();
    check("nocnt_count", xfer_count, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
